// File: rtl/noc_route_pkg.sv
// Shared route typedef and head-routing function for the tree-NoC splitters.
package noc_route_pkg;

  typedef enum logic {
    ROUTE_P0 = 1'b0,
    ROUTE_P1 = 1'b1
  } route_e;

  // Addresses are passed left-aligned in RT_W bits, so one function serves any ADDR_W.
  localparam int RT_W = 32;

  function automatic route_e route_of(input logic [RT_W-1:0] addr,
                                      input logic [RT_W-1:0] node_addr,
                                      input int              level,
                                      input bit              leaf);
    logic [RT_W-1:0] mask;
    logic [RT_W-1:0] shifted;
    mask    = ~({RT_W{1'b1}} >> level);
    shifted = addr << level;
    if (leaf) begin
      return (((addr ^ node_addr) & mask) == '0) ? ROUTE_P0 : ROUTE_P1;
    end
    return shifted[RT_W-1] ? ROUTE_P1 : ROUTE_P0;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head entry is read combinationally.
module noc_sync_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_route_split.sv
// Two-way buffered route splitter with separate sel token channel.
// Optional per-port retire counters when ROUTE_STATS_EN is defined.
module noc_route_split
  import noc_route_pkg::*;
#(
  parameter int                DATA_W = 9,
  parameter int                ADDR_W = 4,
  parameter int                LEVEL  = 2,
  parameter logic [ADDR_W-1:0] ADDR   = 4'b1100,
  parameter int                LEAF   = 0,
  parameter int                DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sel_valid,
  input  logic              sel_ready,
  output logic              sel
`ifdef ROUTE_STATS_EN
  ,
  output logic [31:0]       stat0,
  output logic [31:0]       stat1
`endif
);

  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;
  logic [RT_W-1:0]   head_addr_al, node_addr_al;
  route_e            route;
  logic              sel_done_q, sel_done_d;
  logic              data_done_q, data_done_d;
  logic              sel_hs, data_hs;

  assign push     = in_valid && !full;
  assign in_ready = !full;

  noc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign head_addr_al = RT_W'(head[DATA_W-1 -: ADDR_W]) << (RT_W - ADDR_W);
  assign node_addr_al = RT_W'(ADDR) << (RT_W - ADDR_W);
  assign route        = route_of(head_addr_al, node_addr_al, LEVEL, LEAF != 0);

  // A channel drops its valid once its half of the transfer is done; the head
  // pops only when both halves are done or completing this cycle.
  always_comb begin
    sel_valid   = !empty && !sel_done_q;
    out0_valid  = !empty && !data_done_q && (route == ROUTE_P0);
    out1_valid  = !empty && !data_done_q && (route == ROUTE_P1);
    sel         = (route == ROUTE_P1);
    out_data    = head;
    sel_hs      = sel_valid && sel_ready;
    data_hs     = (out0_valid && out0_ready) || (out1_valid && out1_ready);
    pop         = !empty && (sel_done_q || sel_hs) && (data_done_q || data_hs);
    sel_done_d  = pop ? 1'b0 : (sel_done_q || sel_hs);
    data_done_d = pop ? 1'b0 : (data_done_q || data_hs);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      sel_done_q  <= sel_done_d;
      data_done_q <= data_done_d;
    end
  end

`ifdef ROUTE_STATS_EN
  logic [31:0] stat0_q, stat1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else if (pop) begin
      if (route == ROUTE_P0) stat0_q <= stat0_q + 32'd1;
      else                   stat1_q <= stat1_q + 32'd1;
    end
  end

  assign stat0 = stat0_q;
  assign stat1 = stat1_q;
`endif

endmodule

// File: doc/noc_route_split.md
# noc_route_split

Clocked, parametrised two-way routing splitter for the tree NoC. It accepts flits on one valid/ready input and buffers them in a DEPTH-entry FIFO. Each head flit is steered to output port 0 or 1 by comparing its destination address field with this node's ADDR/LEVEL. A route-select token is emitted on a separate sel channel. It replaces the fixed 9-bit/4-bit-address splitter and adds buffering, a per-node address/level setting, and leaf/internal mode as parameters.

## Interface
Parameters:
- DATA_W, 9: flit width; the address field is flit[DATA_W-1 -: ADDR_W].
- ADDR_W, 4: destination address width; 1 ≤ ADDR_W < DATA_W.
- LEVEL, 2: tree depth of this node; 0 ≤ LEVEL ≤ ADDR_W-1.
- ADDR, 4'b1100: node address; only the top LEVEL bits are significant.
- LEAF, 0: 1 selects leaf compare mode; 0 selects internal bit-test mode.
- DEPTH, 2: input FIFO entries; a power of two, ≥ 2.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_valid / in_ready, in / out, 1: input handshake.
- in_data, in, DATA_W: input flit.
- out0_valid / out0_ready, out / in, 1: port 0 handshake.
- out1_valid / out1_ready, out / in, 1: port 1 handshake.
- out_data, out, DATA_W: head flit, shared by both ports.
- sel_valid / sel_ready, out / in, 1: route-token handshake.
- sel, out, 1: 0 means port 0, 1 means port 1.
- stat0, stat1, out, 32: per-port retired-flit counts; present only with ROUTE_STATS_EN.

## Operation
- Mask: M = top LEVEL bits of ADDR_W set, all others clear. A = address field of the head flit.
- Leaf mode (LEAF=1): route is 0 if (A & M) == (ADDR & M), otherwise 1.
- Internal mode (LEAF=0): route is A[ADDR_W-1-LEVEL]. A 0 goes to port 0; a 1 goes to port 1.
- Head routing is combinational from the FIFO head entry. The route is stable while the entry is at the head.
- When the FIFO is non-empty, sel_valid and out{route}_valid are asserted. The other port's valid stays 0.
- Two done flags, sel_done and data_done, are set on their respective handshakes.
- The head entry retires, popping the FIFO, in the cycle where both handshakes are complete: each flag is either already set or completing that cycle. Both flags clear on retire.
- A channel whose flag is set deasserts its valid until the head retires.
- sel and data handshakes may complete in either order or in the same cycle.
- in_ready = !full, registered, with no same-cycle pass-through when full.
- Push and pop in the same cycle are allowed whenever the FIFO is not full. Occupancy is then unchanged.
- Pointers are log2(DEPTH)+1 bits wide and wrap naturally.

## Timing
- Reset, synchronous: FIFO empties. All valids go to 0, in_ready to 1, done flags to 0, stat counters to 0.
- Reset asserted mid-transfer drops any buffered flits without emitting them.
- Outputs during reset: out_data and sel are don't-care while their valids are 0.
- Latency: a flit accepted at edge t presents valid in the cycle after edge t. Minimum sustained throughput is one flit per cycle with all readies held at 1.
- Empty FIFO: no valid is asserted, and in_data does not bypass to the outputs.
- Full FIFO: in_ready is 0 and in_data is ignored.

## Configuration
- ROUTE_STATS_EN: when defined, stat0 and stat1 increment by 1 when a flit routed to that port retires. They wrap at 2^32.
- Without ROUTE_STATS_EN, the stat ports and counters are absent.

## Structure
- Package noc_route_pkg holds the route typedef (enum ROUTE_P0 = 0, ROUTE_P1 = 1) and the function route_of(addr, ADDR, LEVEL, LEAF), which is shared with later splitter variants.
- Sub-module noc_sync_fifo (DATA_W, DEPTH) provides full/empty, push/pop and head data.
- The top level contains the routing, done-flag and handshake logic.

## Test plan
- Default parameters, internal mode, all readies at 1; push addresses 4'b0000 and 4'b0010 -> first goes to port 0, second to port 1, sel = 0 then 1, one per cycle.
- LEAF=1, ADDR=4'b1100, LEVEL=2; addresses 4'b1101 and 4'b1001 -> port 0 / sel 0, then port 1 / sel 1.
- sel_ready held at 0 for 3 cycles with out0_ready at 1 -> data handshake completes once and out0_valid drops. The head retires only when sel_ready rises, with no duplicate data transfer.
- All readies at 0 and 3 pushes with DEPTH=2 -> in_ready falls after 2 accepts and the third flit is held off. Releasing the readies drains both in order; then in_ready is 1.
- Reset asserted with 2 flits buffered -> next cycle all valids are 0 and in_ready is 1. Stats read 0 under ROUTE_STATS_EN.
- ROUTE_STATS_EN defined, 5 flits to port 0 and 3 to port 1 -> stat0 = 5, stat1 = 3.
